// File: rtl/coin_tally_if.sv
// Pickup-event handshake between the coin tally and its consumer (HUD/sound).
// The tally drives valid/coin/player through the master side; the consumer
// answers with ready through the slave side.
interface coin_tally_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_coin;
  logic       evt_player;

  modport master (
    output evt_valid,
    output evt_coin,
    output evt_player,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_coin,
    input  evt_player,
    output evt_ready
  );
endinterface

// File: rtl/coin_tally.sv
// Coin tally: synchronises the per-coin pickup flags, queues rising edges as
// pending credits, and hands them out one at a time (lowest index first) as
// events while keeping two-digit BCD scores per player and a per-level total.
module coin_tally #(
  parameter int NCOIN = 10
) (
  input  logic             frame_clk,
  input  logic             RESET_n,
  input  logic [NCOIN-1:0] taken,
  input  logic [NCOIN-1:0] owner,
  input  logic             level_start,
  coin_tally_if.master     evt,
  output logic [7:0]       score0,
  output logic [7:0]       score1,
  output logic [3:0]       total,
  output logic             all_taken
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [3:0] LP_NCOIN = 4'(NCOIN);

  state_t           r_state;
  state_t           w_next_state;

  logic [NCOIN-1:0] r_s1;
  logic [NCOIN-1:0] r_s2;
  logic [NCOIN-1:0] r_s3;
  logic [NCOIN-1:0] r_pending;

  logic [NCOIN-1:0] w_rise;
  logic [NCOIN-1:0] w_set;
  logic [NCOIN-1:0] w_clr;
  logic [NCOIN-1:0] w_sel_mask;
  logic [3:0]       w_sel_idx;
  logic             w_found;
  logic             w_any_pending;
  logic             w_sel_owner;

  logic [3:0]       r_evt_coin;
  logic             r_evt_player;
  logic             r_evt_valid;
  logic [7:0]       r_score0;
  logic [7:0]       r_score1;
  logic [3:0]       r_total;
  logic             r_all_taken;

  // Two-digit BCD increment that sticks at 99 instead of rolling over.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'h99) begin
      result = 8'h99;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

  // A pickup is a 0->1 transition seen after the synchroniser; once the level
  // is complete further edges are dropped, and the coin being served in SCAN
  // is retired from the pending set in the same edge.
  assign w_rise        = r_s2 & ~r_s3;
  assign w_set         = (r_state == DONE) ? '0 : w_rise;
  assign w_clr         = (r_state == SCAN) ? w_sel_mask : '0;
  assign w_any_pending = |r_pending;
  assign w_sel_owner   = |(owner & w_sel_mask);

  // Lowest-index pending coin, as both an index and a one-hot mask.
  always_comb begin
    w_sel_idx  = '0;
    w_sel_mask = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NCOIN; i++) begin
      if (r_pending[i] && !w_found) begin
        w_found       = 1'b1;
        w_sel_idx     = 4'(i);
        w_sel_mask[i] = 1'b1;
      end
    end
  end

  // Synchroniser plus history flop; keeps sampling through level_start so a
  // coin that is still held high is not seen as a fresh pickup.
  always_ff @(posedge frame_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= taken;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending credits: a new edge and the SCAN retirement can hit different
  // coins in the same cycle, and both must land.
  always_ff @(posedge frame_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_pending <= '0;
    end else if (level_start) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // Next-state logic; level_start overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    if (level_start) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_pending) w_next_state = SCAN;
        end
        SCAN: begin
          w_next_state = EMIT;
        end
        EMIT: begin
          if (r_evt_valid && evt.evt_ready) begin
            if (r_total == LP_NCOIN)  w_next_state = DONE;
            else if (w_any_pending)   w_next_state = SCAN;
            else                      w_next_state = IDLE;
          end
        end
        DONE: begin
          w_next_state = DONE;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // State register, with valid and all_taken registered from the next state so
  // neither depends combinationally on evt_ready.
  always_ff @(posedge frame_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= IDLE;
      r_evt_valid <= 1'b0;
      r_all_taken <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_evt_valid <= (w_next_state == EMIT);
      r_all_taken <= (w_next_state == DONE);
    end
  end

  // SCAN latches the event fields and credits the owning player and the total.
  always_ff @(posedge frame_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_evt_coin   <= '0;
      r_evt_player <= 1'b0;
      r_score0     <= '0;
      r_score1     <= '0;
      r_total      <= '0;
    end else if (level_start) begin
      r_score0 <= '0;
      r_score1 <= '0;
      r_total  <= '0;
    end else if (r_state == SCAN) begin
      r_evt_coin   <= w_sel_idx;
      r_evt_player <= w_sel_owner;
      r_total      <= r_total + 4'd1;
      if (w_sel_owner) begin
        r_score1 <= bcd_inc(r_score1);
      end else begin
        r_score0 <= bcd_inc(r_score0);
      end
    end
  end

  assign evt.evt_valid  = r_evt_valid;
  assign evt.evt_coin   = r_evt_coin;
  assign evt.evt_player = r_evt_player;
  assign score0         = r_score0;
  assign score1         = r_score1;
  assign total          = r_total;
  assign all_taken      = r_all_taken;

endmodule
